id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register with operand forwarding for the MIPS
//             execute stage. It captures the decoded instruction each cycle,
//             forwards EX/MEM and MEM/WB results into the ALU operands, and
//             detects load-use hazards. A load-use hazard is answered with a
//             one-cycle ID stall plus a bubble into EX.
//  Ports    :
//    clk, rst            - rising-edge clock, synchronous active-high reset
//    id_*                - decoded instruction fields coming from ID
//    mem_fwd_*           - EX/MEM result port (highest forwarding priority)
//    wb_fwd_*            - MEM/WB result port
//    stall_in, flush     - downstream hold request / kill entering instruction
//    stall_id            - ID/IF must hold this cycle
//    ex_valid, ex_rd,
//    ex_reg_write,
//    ex_mem_read,
//    ex_mem_write        - registered instruction status for later stages
//    rega, regb, control - ALU operands and opcode
//    ex_store_data       - forwarded rt value for stores
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_SIZE    = 4,
    parameter int REG_BITS   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_BITS-1:0]   id_rs,
    input  logic [REG_BITS-1:0]   id_rt,
    input  logic [REG_BITS-1:0]   id_rd,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_shift_imm,
    input  logic [4:0]            id_shamt,
    input  logic [OP_SIZE-1:0]    id_control,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  mem_fwd_we,
    input  logic [REG_BITS-1:0]   mem_fwd_addr,
    input  logic [DATA_WIDTH-1:0] mem_fwd_data,
    input  logic                  wb_fwd_we,
    input  logic [REG_BITS-1:0]   wb_fwd_addr,
    input  logic [DATA_WIDTH-1:0] wb_fwd_data,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic [REG_BITS-1:0]   ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [DATA_WIDTH-1:0] rega,
    output logic [DATA_WIDTH-1:0] regb,
    output logic [OP_SIZE-1:0]    control,
    output logic [DATA_WIDTH-1:0] ex_store_data
);

    localparam int c_SHAMT_BITS = 5;

    // ID/EX pipeline register
    logic                  r_valid;
    logic [REG_BITS-1:0]   r_rs;
    logic [REG_BITS-1:0]   r_rt;
    logic [REG_BITS-1:0]   r_rd;
    logic [DATA_WIDTH-1:0] r_rs_data;
    logic [DATA_WIDTH-1:0] r_rt_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic                  r_use_imm;
    logic                  r_shift_imm;
    logic [4:0]            r_shamt;
    logic [OP_SIZE-1:0]    r_control;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;

    logic                  w_id_reads_rt;
    logic                  w_load_use;
    logic [DATA_WIDTH-1:0] w_rs_f;
    logic [DATA_WIDTH-1:0] w_rt_f;

    // rt is a true source operand unless it is only the destination of an
    // immediate-form instruction; stores and immediate shifts still read it.
    assign w_id_reads_rt = !id_use_imm || id_mem_write || id_shift_imm;

    // A load in EX cannot forward its data yet, so a dependent ID
    // instruction has to wait one cycle and then pick it up from EX/MEM.
    assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                        ((id_rs == r_rd) || ((id_rt == r_rd) && w_id_reads_rt));

    assign stall_id = (w_load_use || stall_in) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall_in && w_load_use)) begin
            r_valid     <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_shift_imm <= 1'b0;
            r_shamt     <= '0;
            r_control   <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!stall_in) begin
            r_valid     <= id_valid;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_use_imm   <= id_use_imm;
            r_shift_imm <= id_shift_imm;
            r_shamt     <= id_shamt;
            r_control   <= id_control;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end
    end

    // Forwarding: EX/MEM beats MEM/WB, and r0 is never forwarded.
    always_comb begin
        w_rs_f = r_rs_data;
        if (mem_fwd_we && (mem_fwd_addr == r_rs) && (r_rs != '0)) begin
            w_rs_f = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == r_rs) && (r_rs != '0)) begin
            w_rs_f = wb_fwd_data;
        end

        w_rt_f = r_rt_data;
        if (mem_fwd_we && (mem_fwd_addr == r_rt) && (r_rt != '0)) begin
            w_rt_f = mem_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == r_rt) && (r_rt != '0)) begin
            w_rt_f = wb_fwd_data;
        end
    end

    // Operand selection. Immediate shifts shift the rt value by shamt.
    always_comb begin
        rega = w_rs_f;
        regb = w_rt_f;
        if (r_shift_imm) begin
            rega = w_rt_f;
            regb = {{(DATA_WIDTH-c_SHAMT_BITS){1'b0}}, r_shamt};
        end else if (r_use_imm) begin
            regb = r_imm;
        end
    end

    assign ex_store_data = w_rt_f;
    assign control       = r_control;
    assign ex_valid      = r_valid;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Self-checking bench for id_ex_stage. Directed steps follow the
//             test plan, then randomized cycles are compared against a
//             behavioural model of the EX-stage instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam logic [3:0] c_ADD = 4'd0;
    localparam logic [3:0] c_SUB = 4'd1;
    localparam logic [3:0] c_SLL = 4'd8;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_shift_imm;
    logic [4:0]  id_shamt;
    logic [3:0]  id_control;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_addr;
    logic [15:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_addr;
    logic [15:0] wb_fwd_data;
    logic        stall_in, flush;
    logic        stall_id;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [15:0] rega, regb;
    logic [3:0]  control;
    logic [15:0] ex_store_data;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_WIDTH(16), .OP_SIZE(4), .REG_BITS(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_shift_imm(id_shift_imm), .id_shamt(id_shamt),
        .id_control(id_control), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .stall_in(stall_in), .flush(flush), .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .rega(rega), .regb(regb), .control(control), .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently sitting in EX
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [15:0] rs_data, rt_data, imm;
        logic        use_imm, shift_imm;
        logic [4:0]  shamt;
        logic [3:0]  control;
        logic        reg_write, mem_read, mem_write;
    } ex_t;

    ex_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Value a register read would see after the newest pending writes
    function automatic logic [15:0] ref_value(input logic [4:0] a, input logic [15:0] d);
        if (a == 5'd0) return d;
        if (mem_fwd_we && mem_fwd_addr == a) return mem_fwd_data;
        if (wb_fwd_we && wb_fwd_addr == a) return wb_fwd_data;
        return d;
    endfunction

    // ID instruction needs a value the load in EX has not produced yet
    function automatic bit ref_load_use();
        bit id_reads_rt;
        id_reads_rt = !id_use_imm || id_mem_write || id_shift_imm;
        if (!(m.valid && m.mem_read && m.rd != 5'd0 && id_valid)) return 1'b0;
        return (id_rs == m.rd) || (id_reads_rt && id_rt == m.rd);
    endfunction

    function automatic ex_t ref_next();
        ex_t n;
        n = m;
        if (rst || flush) n = '0;
        else if (stall_in) n = m;
        else if (ref_load_use()) n = '0;
        else begin
            n.valid = id_valid; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
            n.rs_data = id_rs_data; n.rt_data = id_rt_data; n.imm = id_imm;
            n.use_imm = id_use_imm; n.shift_imm = id_shift_imm; n.shamt = id_shamt;
            n.control = id_control; n.reg_write = id_reg_write;
            n.mem_read = id_mem_read; n.mem_write = id_mem_write;
        end
        return n;
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] rs_v, rt_v, ea, eb;
        rs_v = ref_value(m.rs, m.rs_data);
        rt_v = ref_value(m.rt, m.rt_data);
        if (m.shift_imm) begin ea = rt_v; eb = {11'd0, m.shamt}; end
        else if (m.use_imm) begin ea = rs_v; eb = m.imm; end
        else begin ea = rs_v; eb = rt_v; end
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m.rd));
        chk({tag, ".flags"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write}),
            32'({m.reg_write, m.mem_read, m.mem_write}));
        chk({tag, ".control"}, 32'(control), 32'(m.control));
        chk({tag, ".rega"}, 32'(rega), 32'(ea));
        chk({tag, ".regb"}, 32'(regb), 32'(eb));
        chk({tag, ".store"}, 32'(ex_store_data), 32'(rt_v));
        chk({tag, ".stall_id"}, 32'(stall_id), 32'((ref_load_use() || stall_in) && !flush));
    endtask

    // Settle, compare, advance one edge, update model
    task automatic tick(input string tag);
        ex_t n;
        #1;
        check_all(tag);
        n = ref_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic idle();
        rst = 0; stall_in = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_use_imm = 0; id_shift_imm = 0; id_shamt = 0; id_control = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_fwd_we = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
        wb_fwd_we = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
    endtask

    task automatic set_id(input int v, input int rs, input int rt, input int rd,
                          input int rsd, input int rtd, input int imm,
                          input int ui, input int si, input int sh, input int ctl,
                          input int rw, input int mr, input int mw);
        id_valid = 1'(v); id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
        id_rs_data = 16'(rsd); id_rt_data = 16'(rtd); id_imm = 16'(imm);
        id_use_imm = 1'(ui); id_shift_imm = 1'(si); id_shamt = 5'(sh);
        id_control = 4'(ctl); id_reg_write = 1'(rw); id_mem_read = 1'(mr);
        id_mem_write = 1'(mw);
    endtask

    task automatic randomize_inputs();
        rst      = ($urandom_range(0, 99) < 3);
        flush    = ($urandom_range(0, 99) < 8);
        stall_in = ($urandom_range(0, 99) < 15);
        id_valid = ($urandom_range(0, 9) < 8);
        id_rs = 5'($urandom_range(0, 7));
        id_rt = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
        id_use_imm   = 1'($urandom_range(0, 1));
        id_shift_imm = ($urandom_range(0, 4) == 0);
        id_shamt     = 5'($urandom);
        id_control   = 4'($urandom);
        id_reg_write = 1'($urandom_range(0, 1));
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_mem_write = ($urandom_range(0, 4) == 0);
        mem_fwd_we = 1'($urandom_range(0, 1));
        mem_fwd_addr = 5'($urandom_range(0, 7));
        mem_fwd_data = 16'($urandom);
        wb_fwd_we = 1'($urandom_range(0, 1));
        wb_fwd_addr = 5'($urandom_range(0, 7));
        wb_fwd_data = 16'($urandom);
    endtask

    initial begin
        // Reset with garbage on every input
        randomize_inputs();
        rst = 1; flush = 0; stall_in = 0;
        @(posedge clk);
        randomize_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        m = '0;
        idle();
        tick("reset");

        // Plain pass: SUB r1(5), r2(3)
        set_id(1, 1, 2, 4, 'h0005, 'h0003, 0, 0, 0, 0, c_SUB, 1, 0, 0);
        tick("pass_id");
        idle();
        chk("pass.rega", 32'(rega), 32'h0005);
        chk("pass.regb", 32'(regb), 32'h0003);
        chk("pass.control", 32'(control), 32'(c_SUB));
        chk("pass.ex_valid", 32'(ex_valid), 32'h1);

        // Forward priority on registered rs=4
        set_id(1, 4, 0, 6, 'h0007, 0, 0, 0, 0, 0, c_ADD, 1, 0, 0);
        tick("fwd_id");
        idle();
        stall_in = 1;
        mem_fwd_we = 1; mem_fwd_addr = 4; mem_fwd_data = 16'h1111;
        wb_fwd_we = 1; wb_fwd_addr = 4; wb_fwd_data = 16'h2222;
        #1 chk("fwd.mem_first", 32'(rega), 32'h1111);
        mem_fwd_we = 0;
        #1 chk("fwd.wb", 32'(rega), 32'h2222);
        mem_fwd_we = 1; mem_fwd_addr = 0; wb_fwd_addr = 0;
        #1 chk("fwd.none", 32'(rega), 32'h0007);
        tick("fwd_hold");
        idle();

        // Load-use: lw r3 in EX, then add r7 = r3 + r2
        set_id(1, 0, 0, 3, 0, 0, 'h0010, 1, 0, 0, c_ADD, 1, 1, 0);
        tick("lw_id");
        set_id(1, 3, 2, 7, 'h0001, 'h0002, 0, 0, 0, 0, c_ADD, 1, 0, 0);
        #1 chk("lu.stall_id", 32'(stall_id), 32'h1);
        tick("lu_stall");
        chk("lu.bubble", 32'(ex_valid), 32'h0);
        mem_fwd_we = 1; mem_fwd_addr = 3; mem_fwd_data = 16'hBEEF;
        #1 chk("lu.released", 32'(stall_id), 32'h0);
        tick("lu_release");
        chk("lu.add_valid", 32'(ex_valid), 32'h1);
        chk("lu.add_rega", 32'(rega), 32'hBEEF);
        chk("lu.add_rd", 32'(ex_rd), 32'd7);
        idle();

        // Shift immediate: SLL r5(0x00F0) by 4
        set_id(1, 7, 5, 8, 'h1234, 'h00F0, 'hFFFF, 0, 1, 4, c_SLL, 1, 0, 0);
        tick("shift_id");
        idle();
        chk("shift.rega", 32'(rega), 32'h00F0);
        chk("shift.regb", 32'(regb), 32'h0004);

        // Stall for 3 cycles with flush on the second
        set_id(1, 1, 2, 9, 'h0A0A, 'h0B0B, 0, 0, 0, 0, c_SUB, 1, 0, 0);
        tick("sf_id");
        set_id(1, 3, 4, 10, 'h1111, 'h2222, 0, 0, 0, 0, c_ADD, 1, 0, 0);
        stall_in = 1;
        tick("sf_stall1");
        chk("sf.held_rd", 32'(ex_rd), 32'd9);
        chk("sf.held_valid", 32'(ex_valid), 32'h1);
        flush = 1;
        #1 chk("sf.flush_stall_id", 32'(stall_id), 32'h0);
        tick("sf_stall2_flush");
        chk("sf.bubble", 32'(ex_valid), 32'h0);
        flush = 0;
        tick("sf_stall3");
        chk("sf.still_bubble", 32'(ex_valid), 32'h0);
        idle();
        tick("sf_done");

        // Randomized cycles against the model
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
